gift_share_collect: RTL and testbench

GIFT_SHARE_COLLECT -- requirements
Module: gift_share_collect

---
 rtl/gift_share_collect.sv | 118 +++++++++++
 tb/tb_gift_share_collect.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gift_share_collect.sv
// gift_share_collect: two-stage share collection for a 3-share masked GIFT S-box.
// S1 registers the raw component-function terms and randomness as a glitch barrier.
// S2 compresses each triple of terms into one share and applies the refresh.
module gift_share_collect (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] terms,
  input  logic [7:0]  rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_sh1,
  output logic [3:0]  out_sh2,
  output logic [3:0]  out_sh3,
  output logic [15:0] out_count
);

  localparam int NCOORD = 4;
  localparam int NTERM  = 9;

  logic [35:0] terms_p1;
  logic [7:0]  rnd_p1;
  logic        vld_p1;
  logic        vld_p2;
  logic [3:0]  sh1_p2;
  logic [3:0]  sh2_p2;
  logic [3:0]  sh3_p2;
  logic [15:0] count_q;
  logic        adv1;
  logic        adv2;
  logic [3:0]  u1;
  logic [3:0]  u2;
  logic [3:0]  u3;
  logic [3:0]  r0;
  logic [3:0]  r1;

  // XOR of the three consecutive terms starting at offset base, per coordinate.
  function automatic logic [3:0] triple_xor(input logic [35:0] t, input int base);
    logic [3:0] u;
    u = '0;
    for (int i = 0; i < NCOORD; i++) begin
      u[i] = t[NTERM*i + base] ^ t[NTERM*i + base + 1] ^ t[NTERM*i + base + 2];
    end
    return u;
  endfunction

  // Gather one refresh bit (odd=0 -> r0, odd=1 -> r1) for every coordinate.
  function automatic logic [3:0] rnd_pick(input logic [7:0] r, input int odd);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < NCOORD; i++) begin
      v[i] = r[2*i + odd];
    end
    return v;
  endfunction

  // A stage may advance when it is empty or its successor is moving.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  // ---- S1 / S2 boundary: terms are combined only from registered copies ----
  assign u1 = triple_xor(terms_p1, 0);
  assign u2 = triple_xor(terms_p1, 3);
  assign u3 = triple_xor(terms_p1, 6);
  assign r0 = rnd_pick(rnd_p1, 0);
  assign r1 = rnd_pick(rnd_p1, 1);

  // S1 data capture; left unreset since vld_p1 qualifies it.
  always_ff @(posedge clk) begin
    if (adv1) begin
      terms_p1 <= terms;
      rnd_p1   <= rnd;
    end
  end

  // S1 valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= in_valid;
    end
  end

  // S2 loads refreshed shares as one snapshot of S1, so shares never mix sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sh1_p2 <= '0;
      sh2_p2 <= '0;
      sh3_p2 <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      sh1_p2 <= u1 ^ r0;
      sh2_p2 <= u2 ^ r1;
      sh3_p2 <= u3 ^ r0 ^ r1;
    end
  end

  // Output transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (vld_p2 && out_ready) begin
      count_q <= count_q + 16'd1;
    end
  end

  // ---- S2 / output boundary: ports driven straight from registers ----
  assign out_valid = vld_p2;
  assign out_sh1   = sh1_p2;
  assign out_sh2   = sh2_p2;
  assign out_sh3   = sh3_p2;
  assign out_count = count_q;

endmodule

// File: tb/tb_gift_share_collect.sv
// Bench for gift_share_collect: randomized traffic against a queue-based
// transaction model plus directed propagation, refresh, stall, reset and wrap cases.
module tb_gift_share_collect;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] terms;
  logic [7:0]  rnd;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sh1;
  logic [3:0]  out_sh2;
  logic [3:0]  out_sh3;
  logic [15:0] out_count;

  gift_share_collect dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .terms     (terms),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh1   (out_sh1),
    .out_sh2   (out_sh2),
    .out_sh3   (out_sh3),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [35:0] t;
    logic [7:0]  r;
    logic [31:0] st;
  } set_t;

  set_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          xfers = 0;
  int          acc = 0;
  logic [31:0] edges = 0;
  logic [15:0] cnt_model = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Share j (0..2) of coordinate i from the definition: XOR of terms 3j..3j+2, then refresh.
  function automatic logic [3:0] model_share(input logic [35:0] t, input logic [7:0] r, input int j);
    logic [3:0] s;
    logic       u;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      u = 1'b0;
      for (int k = 3*j; k < 3*j + 3; k++) u = u ^ t[9*i + k];
      if (j == 0) s[i] = u ^ r[2*i];
      else if (j == 1) s[i] = u ^ r[2*i+1];
      else s[i] = u ^ r[2*i] ^ r[2*i+1];
    end
    return s;
  endfunction

  // Unmasked value: parity of all nine terms per coordinate.
  function automatic logic [3:0] model_parity(input logic [35:0] t);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 9; k++) p[i] = p[i] ^ t[9*i + k];
    return p;
  endfunction

  function automatic logic [35:0] rand_terms();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[35:0];
  endfunction

  // One clock: drive at the negedge, check, predict, and return at the next negedge.
  task automatic cycle(input logic iv, input logic [35:0] t, input logic [7:0] r, input logic ordy);
    logic exp_ir;
    logic exp_ov;
    set_t f;
    set_t n;
    in_valid  = iv;
    terms     = t;
    rnd       = r;
    out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (q[0].st < edges);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("out_count", 64'(out_count), 64'(cnt_model));
    if (exp_ov) begin
      f = q[0];
      chk("sh1", 64'(out_sh1), 64'(model_share(f.t, f.r, 0)));
      chk("sh2", 64'(out_sh2), 64'(model_share(f.t, f.r, 1)));
      chk("sh3", 64'(out_sh3), 64'(model_share(f.t, f.r, 2)));
      chk("unmasked", 64'(out_sh1 ^ out_sh2 ^ out_sh3), 64'(model_parity(f.t)));
      if (ordy) begin
        void'(q.pop_front());
        xfers++;
        cnt_model = cnt_model + 16'd1;
      end
    end
    if (iv && exp_ir) begin
      n.t  = t;
      n.r  = r;
      n.st = edges + 32'd1;
      q.push_back(n);
      acc++;
    end
    @(posedge clk);
    edges = edges + 32'd1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 36'h0, 8'h0, ordy);
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sh", 64'({out_sh1, out_sh2, out_sh3}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cnt_model = 16'd0;
  endtask

  initial begin
    int a0;
    int x0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    terms = '0;
    rnd = '0;
    @(negedge clk);
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_out_count", 64'(out_count), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single-term propagation.
    cycle(1'b1, 36'h1, 8'h00, 1'b1);
    cycle(1'b0, 36'h0, 8'h00, 1'b0);
    chk("prop_valid", 64'(out_valid), 64'd1);
    chk("prop_sh1", 64'(out_sh1), 64'b0001);
    chk("prop_sh2", 64'(out_sh2), 64'd0);
    chk("prop_sh3", 64'(out_sh3), 64'd0);
    cycle(1'b0, 36'h0, 8'h00, 1'b1);
    chk("prop_count", 64'(out_count), 64'd1);

    // Refresh.
    cycle(1'b1, 36'h1, 8'h03, 1'b1);
    cycle(1'b0, 36'h0, 8'h00, 1'b0);
    chk("ref_sh1", 64'(out_sh1), 64'b0000);
    chk("ref_sh2", 64'(out_sh2), 64'b0001);
    chk("ref_sh3", 64'(out_sh3), 64'b0000);
    chk("ref_xor", 64'(out_sh1 ^ out_sh2 ^ out_sh3), 64'b0001);
    idle(2, 1'b1);

    // Back-to-back random traffic.
    x0 = xfers;
    for (int i = 0; i < 100; i++) cycle(1'b1, rand_terms(), 8'($urandom()), 1'b1);
    idle(2, 1'b1);
    chk("b2b_outputs", 64'(xfers - x0), 64'd100);

    // Backpressure: only two sets fit while the consumer stalls.
    a0 = acc;
    x0 = xfers;
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_terms(), 8'($urandom()), 1'b0);
    chk("bp_accepted", 64'(acc - a0), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    idle(4, 1'b1);
    chk("bp_delivered", 64'(xfers - x0), 64'd2);

    // Random valid/ready mix.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), rand_terms(), 8'($urandom()), 1'($urandom_range(0, 1)));
    idle(3, 1'b1);

    // Reset with both stages full; nothing stale may surface afterwards.
    cycle(1'b1, rand_terms(), 8'($urandom()), 1'b0);
    cycle(1'b1, rand_terms(), 8'($urandom()), 1'b0);
    chk("mid_full", 64'(in_ready), 64'd0);
    pulse_reset();
    x0 = xfers;
    idle(4, 1'b1);
    chk("mid_no_stale", 64'(xfers - x0), 64'd0);
    cycle(1'b1, rand_terms(), 8'($urandom()), 1'b1);
    idle(3, 1'b1);
    chk("mid_fresh", 64'(xfers - x0), 64'd1);

    // Counter wrap after 65536 transfers from reset.
    pulse_reset();
    x0 = xfers;
    for (int n = 0; n < 70000 && (xfers - x0) < 65536; n++)
      cycle(1'b1, rand_terms(), 8'($urandom()), 1'b1);
    chk("wrap_xfers", 64'(xfers - x0), 64'd65536);
    chk("wrap_count", 64'(out_count), 64'd0);
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
